// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for inst_sequencer: FSM states, the 34-bit core
// instruction field map and helpers that build instruction words.
package inst_sequencer_pkg;

  localparam int unsigned INST_W = 34;
  localparam int unsigned CNT_W  = 11;

  localparam int unsigned I_ACC      = 33;
  localparam int unsigned I_CEN_P    = 32;
  localparam int unsigned I_WEN_P    = 31;
  localparam int unsigned I_AP_LSB   = 20;
  localparam int unsigned I_CEN_X    = 19;
  localparam int unsigned I_WEN_X    = 18;
  localparam int unsigned I_AX_LSB   = 7;
  localparam int unsigned I_OFIFO_RD = 6;
  localparam int unsigned I_IFIFO_WR = 5;
  localparam int unsigned I_IFIFO_RD = 4;
  localparam int unsigned I_L0_RD    = 3;
  localparam int unsigned I_L0_WR    = 2;
  localparam int unsigned I_EXEC     = 1;
  localparam int unsigned I_LOAD     = 0;

  // Both SRAMs deselected (active-low CEN/WEN high), every strobe low.
  localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WW,
    S_WL0,
    S_KLOAD,
    S_KGAP,
    S_AW,
    S_AL0,
    S_EXEC,
    S_DRAIN,
    S_WB,
    S_DONE
  } state_t;

  function automatic logic [INST_W-1:0] xmem_op(input logic wr, input logic [CNT_W-1:0] addr);
    logic [INST_W-1:0] r;
    r                     = INST_IDLE;
    r[I_CEN_X]            = 1'b0;
    r[I_WEN_X]            = ~wr;
    r[I_AX_LSB +: CNT_W]  = addr;
    return r;
  endfunction

  function automatic logic [INST_W-1:0] pmem_wr(input logic [CNT_W-1:0] addr);
    logic [INST_W-1:0] r;
    r                     = INST_IDLE;
    r[I_CEN_P]            = 1'b0;
    r[I_WEN_P]            = 1'b0;
    r[I_AP_LSB +: CNT_W]  = addr;
    return r;
  endfunction

endpackage

// File: rtl/inst_sequencer_phase_cnt.sv
// Loadable down-counter timing every sequencer phase; done_o marks the
// final step of the loaded length, en=0 holds the count.
module seq_phase_cnt
  import inst_sequencer_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done_o
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done_o = (count == '0);

endmodule

// File: rtl/inst_sequencer.sv
// Layer-level instruction generator in front of core: host load, L0 fill,
// kernel load, execute, drain and psum writeback. Optional INST_SEQ_PAUSE_EN
// adds a pause input that freezes the pass.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int          bw        = 4,
  parameter int          psum_bw   = 16,
  parameter int          col       = 8,
  parameter int          row       = 8,
  parameter int          len_act   = 36,
  parameter logic [10:0] W_BASE    = 11'h400,
  parameter int          DRAIN_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [bw*row-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                ofifo_valid,
`ifdef INST_SEQ_PAUSE_EN
  input  logic                pause,
`endif
  output logic [INST_W-1:0]   inst,
  output logic [bw*row-1:0]   D_xmem,
  output logic                busy,
  output logic                done
);

  if (psum_bw < 1 || len_act > int'(W_BASE) || DRAIN_CYC < row + col) begin : g_param_check
    $error("inst_sequencer: illegal parameter combination");
  end

  state_t             state, next_state;
  logic [CNT_W-1:0]   idx, idx_d;
  logic               pend, pend_d;
  logic               cnt_load, cnt_en, cnt_last;
  logic [CNT_W-1:0]   cnt_val;
  logic [INST_W-1:0]  inst_d;
  logic [bw*row-1:0]  dx_d;
  logic               in_ready_d, busy_d, done_d;
  logic               hs, freeze, pause_i;

`ifdef INST_SEQ_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  assign hs = in_valid && in_ready;
  // in_ready is registered, so a handshake already offered when pause rises
  // is honoured instead of being dropped.
  assign freeze = pause_i && !hs && (state != S_DONE);

  seq_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .done_o   (cnt_last)
  );

  always_comb begin
    next_state = state;
    idx_d      = idx;
    pend_d     = pend;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_en     = 1'b0;
    inst_d     = INST_IDLE;
    dx_d       = '0;

    if (freeze) begin
      if (pend) begin
        inst_d = pmem_wr(idx);
        idx_d  = idx + CNT_W'(1);
        pend_d = 1'b0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            next_state = S_WW;
            cnt_load   = 1'b1;
            cnt_val    = CNT_W'(col - 1);
            idx_d      = '0;
          end
        end
        S_WW: begin
          if (hs) begin
            inst_d = xmem_op(1'b1, W_BASE + idx);
            dx_d   = in_data;
            cnt_en = 1'b1;
            idx_d  = idx + CNT_W'(1);
            if (cnt_last) begin
              next_state = S_WL0;
              cnt_load   = 1'b1;
              cnt_val    = CNT_W'(col);
              idx_d      = '0;
            end
          end
        end
        S_WL0: begin
          if (idx < CNT_W'(col)) inst_d = xmem_op(1'b0, W_BASE + idx);
          if (idx != '0) inst_d[I_L0_WR] = 1'b1;
          cnt_en = 1'b1;
          idx_d  = idx + CNT_W'(1);
          if (cnt_last) begin
            next_state = S_KLOAD;
            cnt_load   = 1'b1;
            cnt_val    = CNT_W'(col - 1);
            idx_d      = '0;
          end
        end
        S_KLOAD: begin
          inst_d[I_L0_RD] = 1'b1;
          inst_d[I_LOAD]  = 1'b1;
          cnt_en          = 1'b1;
          if (cnt_last) begin
            next_state = S_KGAP;
            cnt_load   = 1'b1;
            cnt_val    = CNT_W'(row - 1);
          end
        end
        S_KGAP: begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            next_state = S_AW;
            cnt_load   = 1'b1;
            cnt_val    = CNT_W'(len_act - 1);
            idx_d      = '0;
          end
        end
        S_AW: begin
          if (hs) begin
            inst_d = xmem_op(1'b1, idx);
            dx_d   = in_data;
            cnt_en = 1'b1;
            idx_d  = idx + CNT_W'(1);
            if (cnt_last) begin
              next_state = S_AL0;
              cnt_load   = 1'b1;
              cnt_val    = CNT_W'(len_act);
              idx_d      = '0;
            end
          end
        end
        S_AL0: begin
          if (idx < CNT_W'(len_act)) inst_d = xmem_op(1'b0, idx);
          if (idx != '0) inst_d[I_L0_WR] = 1'b1;
          cnt_en = 1'b1;
          idx_d  = idx + CNT_W'(1);
          if (cnt_last) begin
            next_state = S_EXEC;
            cnt_load   = 1'b1;
            cnt_val    = CNT_W'(len_act - 1);
          end
        end
        S_EXEC: begin
          inst_d[I_L0_RD] = 1'b1;
          inst_d[I_EXEC]  = 1'b1;
          cnt_en          = 1'b1;
          if (cnt_last) begin
            next_state = S_DRAIN;
            cnt_load   = 1'b1;
            cnt_val    = CNT_W'(DRAIN_CYC - 1);
          end
        end
        S_DRAIN: begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            next_state = S_WB;
            idx_d      = '0;
            pend_d     = 1'b0;
          end
        end
        S_WB: begin
          // idx counts pmem writes issued; pend marks a read awaiting its write
          if ((idx == CNT_W'(len_act)) && !pend) begin
            next_state = S_DONE;
          end else begin
            if (pend) begin
              inst_d = pmem_wr(idx);
              idx_d  = idx + CNT_W'(1);
              pend_d = 1'b0;
            end
            if (ofifo_valid &&
                (({1'b0, idx} + {{CNT_W{1'b0}}, pend}) < (CNT_W+1)'(len_act))) begin
              inst_d[I_OFIFO_RD] = 1'b1;
              pend_d             = 1'b1;
            end
          end
        end
        S_DONE: next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end

    inst_d[I_ACC]      = 1'b0;
    inst_d[I_IFIFO_WR] = 1'b0;
    inst_d[I_IFIFO_RD] = 1'b0;

    in_ready_d = ((next_state == S_WW) || (next_state == S_AW)) && !pause_i;
    busy_d     = (next_state != S_IDLE);
    done_d     = (next_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      pend     <= 1'b0;
      inst     <= INST_IDLE;
      D_xmem   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= next_state;
      idx      <= idx_d;
      pend     <= pend_d;
      inst     <= inst_d;
      D_xmem   <= dx_d;
      in_ready <= in_ready_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule
